priority_encoder_4_2_seq: RTL and testbench

Sequential 4-to-2 priority encoder with request capture and a valid/ready output. It latches up to four request lines into a pending set and emits one 2-bit index per accepted transfer, highest-priority first or round-robin. It then clears the served request. It sits upstream of the team's 2-to-4 decoders, so that four request sources can share one 2-bit select bus.

---
 rtl/priority_enc_pkg.sv | 24 ++
 rtl/priority_pick4.sv | 33 +++
 rtl/priority_encoder_4_2_seq.sv | 118 +++++++++++
 tb/tb_priority_encoder_4_2_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/priority_enc_pkg.sv
// Shared types and constants for the sequential 4-to-2 priority encoder.
package priority_enc_pkg;

    localparam int CODE_W = 2;
    localparam int N_REQ  = 4;

    localparam logic PRIO_FIXED = 1'b0;
    localparam logic PRIO_RR    = 1'b1;

    // IDLE: nothing offered. HOLD: a code is offered and waits for its handshake.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // One-hot mask of a request index.
    function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] idx);
        logic [N_REQ-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/priority_pick4.sv
// Combinational pick of one index out of a 4-bit mask, fixed priority
// (3 highest) or round-robin (search upward from ptr+1, wrapping).
module priority_pick4
    import priority_enc_pkg::*;
(
    input  logic [N_REQ-1:0]  mask,
    input  logic [CODE_W-1:0] ptr,
    input  logic              mode,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    logic [CODE_W-1:0] probe;

    // Later loop iterations overwrite earlier ones, so the last hit is the winner.
    always_comb begin
        idx   = '0;
        probe = '0;
        any   = |mask;
        if (mode == PRIO_FIXED) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (mask[i]) idx = CODE_W'(i);
            end
        end else begin
            // k = N_REQ lands on ptr itself (lowest priority), k = 1 on ptr+1 (highest).
            for (int k = N_REQ; k >= 1; k--) begin
                probe = ptr + CODE_W'(k);
                if (mask[probe]) idx = probe;
            end
        end
    end

endmodule

// File: rtl/priority_encoder_4_2_seq.sv
// Sequential 4-to-2 priority encoder: captures request pulses into a pending
// set and hands out one 2-bit index per accepted transfer.
//
// Handshake: a transfer completes on a rising edge where out_valid=1 and
// out_ready=1. Once out_valid rises, out_valid and code stay put until that
// happens (only reset may drop them); out_valid does not depend on out_ready.
module priority_encoder_4_2_seq
    import priority_enc_pkg::*;
#(
    parameter bit PRIO_MODE = PRIO_FIXED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_REQ-1:0]  req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code,
    output logic [N_REQ-1:0]  pending,
    output logic              overflow,
    output state_e            dbg_state
);

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  pending_q, pending_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              overflow_q, overflow_d;
    // Index where the next round-robin search starts (last served + 1).
    // Resetting it to 0 gives index 0 first priority after reset.
    logic [CODE_W-1:0] rr_start_q, rr_start_d;

    logic              handshake;
    logic [N_REQ-1:0]  served;
    logic [N_REQ-1:0]  cand;
    logic [N_REQ-1:0]  req_in;
    logic [CODE_W-1:0] pick_ptr;
    logic [CODE_W-1:0] pick_idx;
    logic              pick_any;

    // Served-bit removal, gated capture and candidate set for the picker.
    always_comb begin
        handshake = valid_q & out_ready;
        served    = handshake ? onehot(code_q) : '0;
        cand      = pending_q & ~served;
        req_in    = enable ? req : '0;
        // After a handshake search from the just-served index + 1.
        pick_ptr  = handshake ? code_q : (rr_start_q - CODE_W'(1));
    end

    priority_pick4 u_pick (
        .mask (cand),
        .ptr  (pick_ptr),
        .mode (PRIO_MODE),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Next-state and output-register logic of the IDLE/HOLD FSM.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        valid_d    = valid_q;
        // A request on the bit being served re-sets it and is not an overflow.
        pending_d  = cand | req_in;
        overflow_d = overflow_q | (|(req_in & pending_q & ~served));
        rr_start_d = handshake ? (code_q + CODE_W'(1)) : rr_start_q;
        case (state_q)
            IDLE: begin
                if (enable && pick_any) begin
                    code_d  = pick_idx;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (handshake) begin
                    if (enable && pick_any) begin
                        code_d = pick_idx;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // All state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            rr_start_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            rr_start_q <= rr_start_d;
        end
    end

    assign out_valid = valid_q;
    assign code      = code_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_priority_encoder_4_2_seq.sv
// Bench for priority_encoder_4_2_seq: a fixed-priority and a round-robin
// instance share one stimulus stream and are checked against a per-instance
// behavioural model, plus directed scenarios with constant expectations.
module tb_priority_encoder_4_2_seq;
    import priority_enc_pkg::*;

    // ---------------- clock / reset / stimulus signals ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] req;
    logic       out_ready;

    always #5 clk = ~clk;

    logic       f_valid, r_valid;
    logic [1:0] f_code, r_code;
    logic [3:0] f_pending, r_pending;
    logic       f_ovf, r_ovf;
    state_e     f_state, r_state;

    priority_encoder_4_2_seq #(.PRIO_MODE(1'b0)) dut_fixed (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
        .out_valid(f_valid), .out_ready(out_ready), .code(f_code),
        .pending(f_pending), .overflow(f_ovf), .dbg_state(f_state)
    );

    priority_encoder_4_2_seq #(.PRIO_MODE(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
        .out_valid(r_valid), .out_ready(out_ready), .code(r_code),
        .pending(r_pending), .overflow(r_ovf), .dbg_state(r_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0 = fixed, 1 = round-robin) ----------------
    bit m_pend[2][4];
    bit m_valid[2];
    int m_code[2];
    bit m_ovf[2];
    int m_last[2];

    // Choose a request from the candidate set by the arbitration rule.
    function automatic int model_pick(input int m, input bit c[4]);
        if (m == 0) begin
            for (int i = 3; i >= 0; i--) if (c[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) if (c[(m_last[m] + k) % 4]) return (m_last[m] + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) m_pend[m][i] = 1'b0;
                m_valid[m] = 1'b0;
                m_code[m]  = 0;
                m_ovf[m]   = 1'b0;
                m_last[m]  = 3;
            end else begin
                bit hs;
                int served;
                int p;
                bit c[4];
                hs     = m_valid[m] && out_ready;
                served = hs ? m_code[m] : -1;
                for (int i = 0; i < 4; i++) begin
                    c[i] = m_pend[m][i] && (i != served);
                    if (enable && req[i] && c[i]) m_ovf[m] = 1'b1;
                end
                if (hs) m_last[m] = m_code[m];
                if (!m_valid[m] || hs) begin
                    p = enable ? model_pick(m, c) : -1;
                    if (p >= 0) begin
                        m_code[m]  = p;
                        m_valid[m] = 1'b1;
                    end else begin
                        m_valid[m] = 1'b0;
                    end
                end
                for (int i = 0; i < 4; i++) m_pend[m][i] = c[i] || (enable && req[i]);
            end
        end
    endtask

    function automatic int model_pend_val(input int m);
        int v = 0;
        for (int i = 0; i < 4; i++) if (m_pend[m][i]) v += (1 << i);
        return v;
    endfunction

    task automatic check_all();
        check_eq("fix_valid",   8'(f_valid),          8'(m_valid[0]));
        check_eq("fix_code",    8'(f_code),           8'(m_code[0]));
        check_eq("fix_pending", 8'(f_pending),        8'(model_pend_val(0)));
        check_eq("fix_ovf",     8'(f_ovf),            8'(m_ovf[0]));
        check_eq("fix_state",   8'(f_state == HOLD),  8'(m_valid[0]));
        check_eq("rr_valid",    8'(r_valid),          8'(m_valid[1]));
        check_eq("rr_code",     8'(r_code),           8'(m_code[1]));
        check_eq("rr_pending",  8'(r_pending),        8'(model_pend_val(1)));
        check_eq("rr_ovf",      8'(r_ovf),            8'(m_ovf[1]));
        check_eq("rr_state",    8'(r_state == HOLD),  8'(m_valid[1]));
    endtask

    // ---------------- driver ----------------
    // Apply inputs for one edge, advance the model at that edge, check at the next falling edge.
    task automatic cycle(input bit r, input bit e, input logic [3:0] q, input bit rdy);
        rst_n     = r;
        enable    = e;
        req       = q;
        out_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0; enable = 1'b0; req = 4'b0000; out_ready = 1'b0;
        do_reset();
        do_reset();
        check_eq("reset_valid",   8'(f_valid),   8'd0);
        check_eq("reset_pending", 8'(f_pending), 8'd0);
        check_eq("reset_code",    8'(f_code),    8'd0);
        check_eq("reset_ovf",     8'(f_ovf),     8'd0);

        // Fixed priority: 0110 pulse -> 2 then 1, then empty.
        cycle(1'b1, 1'b1, 4'b0110, 1'b1);
        check_eq("fp_pend_n",  8'(f_pending), 8'd6);
        cycle(1'b1, 1'b1, 4'b0000, 1'b1);
        check_eq("fp_code_n1", 8'(f_code),    8'd2);
        check_eq("fp_vld_n1",  8'(f_valid),   8'd1);
        cycle(1'b1, 1'b1, 4'b0000, 1'b1);
        check_eq("fp_code_n2", 8'(f_code),    8'd1);
        cycle(1'b1, 1'b1, 4'b0000, 1'b1);
        check_eq("fp_vld_end", 8'(f_valid),   8'd0);
        check_eq("fp_pend_end", 8'(f_pending), 8'd0);

        // Backpressure: code 3 held for 5 cycles, one transfer on ready.
        do_reset();
        cycle(1'b1, 1'b1, 4'b1000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 4'b0000, 1'b0);
            check_eq("bp_code",  8'(f_code),  8'd3);
            check_eq("bp_valid", 8'(f_valid), 8'd1);
        end
        cycle(1'b1, 1'b1, 4'b0000, 1'b1);
        check_eq("bp_drop", 8'(f_valid), 8'd0);

        // Overflow on a re-request of a pending, unserved bit.
        do_reset();
        cycle(1'b1, 1'b1, 4'b0010, 1'b0);
        check_eq("ovf_before", 8'(f_ovf), 8'd0);
        cycle(1'b1, 1'b1, 4'b0010, 1'b0);
        check_eq("ovf_set", 8'(f_ovf), 8'd1);

        // Set wins over serve on the same bit.
        do_reset();
        cycle(1'b1, 1'b1, 4'b0100, 1'b0);
        cycle(1'b1, 1'b1, 4'b0000, 1'b0);
        check_eq("sw_code", 8'(f_code), 8'd2);
        cycle(1'b1, 1'b1, 4'b0100, 1'b1);
        check_eq("sw_pend", 8'(f_pending), 8'd4);
        check_eq("sw_ovf",  8'(f_ovf),     8'd0);
        cycle(1'b1, 1'b1, 4'b0000, 1'b0);
        check_eq("sw_again_code",  8'(f_code),  8'd2);
        check_eq("sw_again_valid", 8'(f_valid), 8'd1);

        // Round-robin with all requests held: 0,1,2,3,0.
        do_reset();
        cycle(1'b1, 1'b1, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 4'b1111, 1'b1);
            check_eq("rr_seq", 8'(r_code), 8'(i % 4));
        end
        check_eq("rr_ovf_set", 8'(r_ovf), 8'd1);

        // Enable gates capture; reset mid-transfer drops everything.
        do_reset();
        cycle(1'b1, 1'b0, 4'b0001, 1'b1);
        check_eq("en_off_pend", 8'(f_pending), 8'd0);
        cycle(1'b1, 1'b1, 4'b0001, 1'b0);
        cycle(1'b1, 1'b1, 4'b0000, 1'b0);
        check_eq("mid_valid_up", 8'(f_valid), 8'd1);
        cycle(1'b0, 1'b1, 4'b0000, 1'b1);
        check_eq("mid_rst_valid", 8'(f_valid),   8'd0);
        check_eq("mid_rst_code",  8'(f_code),    8'd0);
        check_eq("mid_rst_pend",  8'(f_pending), 8'd0);
        check_eq("mid_rst_ovf",   8'(f_ovf),     8'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            bit         r_b;
            bit         e_b;
            bit         rdy_b;
            logic [3:0] q_b;
            r_b   = ($urandom_range(0, 79) != 0);
            e_b   = ($urandom_range(0, 5) != 0);
            rdy_b = ($urandom_range(0, 2) != 0);
            q_b   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            cycle(r_b, e_b, q_b, rdy_b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
